// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle MIPS control sequencer.
//   - FSM state encoding (visible on state_o)
//   - datapath mux select codes (ALU-A, ALU-B, PC source) and ALU op codes
//   - primary opcode constants and the instruction class enum
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RST = 3'd0,
        ST_IF  = 3'd1,
        ST_ID  = 3'd2,
        ST_EX  = 3'd3,
        ST_MEM = 3'd4,
        ST_WB  = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CLS_NOP  = 4'd0,
        CLS_R    = 4'd1,
        CLS_ADDI = 4'd2,
        CLS_ORI  = 4'd3,
        CLS_LW   = 4'd4,
        CLS_SW   = 4'd5,
        CLS_BEQ  = 4'd6,
        CLS_J    = 4'd7,
        CLS_MFC0 = 4'd8
    } opclass_e;

    // ALU-B operand select
    localparam logic [2:0] ALUB_FOUR  = 3'd0;
    localparam logic [2:0] ALUB_RT    = 3'd1;
    localparam logic [2:0] ALUB_EXT16 = 3'd2;
    localparam logic [2:0] ALUB_EXT18 = 3'd3;
    localparam logic [2:0] ALUB_ZERO  = 3'd4;
    localparam logic [2:0] ALUB_CP0   = 3'd5;
    localparam logic [2:0] ALUB_NONE  = 3'd7;

    // ALU-A operand select
    localparam logic [1:0] ALUA_PC   = 2'd0;
    localparam logic [1:0] ALUA_RS   = 2'd1;
    localparam logic [1:0] ALUA_ZERO = 2'd2;

    // ALU operation
    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;

    // PC source
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_COP0  = 6'h10;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: instruction/data memory handshake between the control
// sequencer (master) and the memory side (slave).
//   imem_req   master->slave  fetch request
//   imem_ready slave->master  fetch complete
//   dmem_req   master->slave  data access request
//   dmem_we    master->slave  data access is a write
//   dmem_ready slave->master  data access complete
interface mc_ctrl_fsm_if;

    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output dmem_ready
    );

endinterface

// File: rtl/mc_opclass_decode.sv
// mc_opclass_decode: combinational instruction class decode.
//   op  in  6  IR[31:26]
//   rs  in  5  IR[25:21], distinguishes MFC0 (rs=0) from other COP0 ops
//   cls out    decoded class; unrecognised encodings decode to CLS_NOP
module mc_opclass_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [4:0] rs,
    output opclass_e   cls
);

    always_comb begin
        cls = CLS_NOP;
        case (op)
            OP_RTYPE: cls = CLS_R;
            OP_ADDI:  cls = CLS_ADDI;
            OP_ORI:   cls = CLS_ORI;
            OP_LW:    cls = CLS_LW;
            OP_SW:    cls = CLS_SW;
            OP_BEQ:   cls = CLS_BEQ;
            OP_J:     cls = CLS_J;
            OP_COP0:  if (rs == 5'd0) cls = CLS_MFC0;
            default:  cls = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle control sequencer for the MIPS datapath.
// Steps each instruction through IF/ID/EX/MEM/WB and drives every datapath
// mux select and register enable, handshakes with instruction/data memory,
// and counts retired instructions.
//   clk, rst_n          clock, asynchronous active-low reset
//   mem (master)        imem/dmem request/ready handshake
//   op, funct, rs       instruction register fields
//   alu_zero            ALU zero flag (BEQ resolution)
//   ir_we, pc_we        IR / PC load strobes; pc_src selects PC source
//   alu_out_we          ALUOut register load
//   rf_we, rf_dst_sel, rf_wdata_sel   register file write controls
//   muxt_alu_a, muxt_alu_b, alu_op    ALU operand selects and operation
//   retire, retired_cnt one-cycle pulse per completed instruction, and count
//   state_o             current state for debug
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    mc_ctrl_fsm_if.master     mem,
    input  logic [5:0]        op,
    input  logic [5:0]        funct,
    input  logic [4:0]        rs,
    input  logic              alu_zero,
    output logic              ir_we,
    output logic              pc_we,
    output logic [1:0]        pc_src,
    output logic              alu_out_we,
    output logic              rf_we,
    output logic              rf_dst_sel,
    output logic              rf_wdata_sel,
    output logic [1:0]        muxt_alu_a,
    output logic [2:0]        muxt_alu_b,
    output logic [2:0]        alu_op,
    output logic              retire,
    output logic [CNT_W-1:0]  retired_cnt,
    output logic [2:0]        state_o
);

    state_e           state_q, state_d;
    opclass_e         cls_q, cls_dec;
    logic [CNT_W-1:0] retired_cnt_q;
    logic             imem_req_c, dmem_req_c, dmem_we_c;

    // funct is interpreted by the ALU itself when alu_op selects FUNCT.
    logic unused_funct;
    assign unused_funct = ^funct;

    mc_opclass_decode u_decode (
        .op  (op),
        .rs  (rs),
        .cls (cls_dec)
    );

    // The class register captures the decode on the single ID cycle so that
    // EX/MEM/WB no longer depend on the IR fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RST;
            cls_q         <= CLS_NOP;
            retired_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_ID) begin
                cls_q <= cls_dec;
            end
            if (retire) begin
                retired_cnt_q <= retired_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        imem_req_c   = 1'b0;
        dmem_req_c   = 1'b0;
        dmem_we_c    = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PCSRC_ALU;
        alu_out_we   = 1'b0;
        rf_we        = 1'b0;
        rf_dst_sel   = 1'b0;
        rf_wdata_sel = 1'b0;
        muxt_alu_a   = ALUA_PC;
        muxt_alu_b   = ALUB_NONE;
        alu_op       = ALU_ADD;
        retire       = 1'b0;

        case (state_q)
            ST_RST: begin
                state_d = ST_IF;
            end

            // PC + 4 is computed every fetch cycle; it is only committed on
            // the cycle the fetch completes.
            ST_IF: begin
                imem_req_c = 1'b1;
                muxt_alu_b = ALUB_FOUR;
                if (mem.imem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = ST_ID;
                end
            end

            // Branch target (PC + offset<<2) is precomputed into ALUOut here.
            ST_ID: begin
                muxt_alu_b = ALUB_EXT18;
                alu_out_we = 1'b1;
                if (cls_dec == CLS_NOP) begin
                    retire  = 1'b1;
                    state_d = ST_IF;
                end else begin
                    state_d = ST_EX;
                end
            end

            ST_EX: begin
                state_d = ST_WB;
                case (cls_q)
                    CLS_R: begin
                        muxt_alu_a = ALUA_RS;
                        muxt_alu_b = ALUB_RT;
                        alu_op     = ALU_FUNCT;
                        alu_out_we = 1'b1;
                    end
                    CLS_ADDI: begin
                        muxt_alu_a = ALUA_RS;
                        muxt_alu_b = ALUB_EXT16;
                        alu_out_we = 1'b1;
                    end
                    CLS_ORI: begin
                        muxt_alu_a = ALUA_RS;
                        muxt_alu_b = ALUB_EXT16;
                        alu_op     = ALU_OR;
                        alu_out_we = 1'b1;
                    end
                    CLS_LW, CLS_SW: begin
                        muxt_alu_a = ALUA_RS;
                        muxt_alu_b = ALUB_EXT16;
                        alu_out_we = 1'b1;
                        state_d    = ST_MEM;
                    end
                    CLS_BEQ: begin
                        muxt_alu_a = ALUA_RS;
                        muxt_alu_b = ALUB_RT;
                        alu_op     = ALU_SUB;
                        pc_we      = alu_zero;
                        pc_src     = PCSRC_ALUOUT;
                        retire     = 1'b1;
                        state_d    = ST_IF;
                    end
                    CLS_J: begin
                        pc_we   = 1'b1;
                        pc_src  = PCSRC_JUMP;
                        retire  = 1'b1;
                        state_d = ST_IF;
                    end
                    CLS_MFC0: begin
                        muxt_alu_a = ALUA_ZERO;
                        muxt_alu_b = ALUB_CP0;
                        alu_out_we = 1'b1;
                    end
                    default: begin
                        state_d = ST_IF;
                    end
                endcase
            end

            ST_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (cls_q == CLS_SW);
                if (mem.dmem_ready) begin
                    if (cls_q == CLS_SW) begin
                        retire  = 1'b1;
                        state_d = ST_IF;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end

            ST_WB: begin
                rf_we        = 1'b1;
                rf_dst_sel   = (cls_q == CLS_R);
                rf_wdata_sel = (cls_q == CLS_LW);
                retire       = 1'b1;
                state_d      = ST_IF;
            end

            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    assign mem.imem_req = imem_req_c;
    assign mem.dmem_req = dmem_req_c;
    assign mem.dmem_we  = dmem_we_c;
    assign retired_cnt  = retired_cnt_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: drives directed and randomized instruction streams into two
// copies of mc_ctrl_fsm (CNT_W=32 and CNT_W=4) and checks every cycle's
// outputs against the expected per-phase behaviour of each instruction class.
module tb_mc_ctrl_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [5:0] op, funct;
    logic [4:0] rs;
    logic       alu_zero, imem_ready, dmem_ready;

    mc_ctrl_fsm_if m32 ();
    mc_ctrl_fsm_if m4 ();
    assign m32.imem_ready = imem_ready;
    assign m32.dmem_ready = dmem_ready;
    assign m4.imem_ready  = imem_ready;
    assign m4.dmem_ready  = dmem_ready;

    logic        ir_we, pc_we, alu_out_we, rf_we, rf_dst_sel, rf_wdata_sel, retire;
    logic [1:0]  pc_src, muxt_alu_a;
    logic [2:0]  muxt_alu_b, alu_op, state_o;
    logic [31:0] retired_cnt;

    logic        ir_we_4, pc_we_4, alu_out_we_4, rf_we_4, rf_dst_sel_4, rf_wdata_sel_4, retire_4;
    logic [1:0]  pc_src_4, muxt_alu_a_4;
    logic [2:0]  muxt_alu_b_4, alu_op_4, state_o_4;
    logic [3:0]  retired_cnt_4;

    mc_ctrl_fsm #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .mem(m32), .op(op), .funct(funct), .rs(rs),
        .alu_zero(alu_zero), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .alu_out_we(alu_out_we), .rf_we(rf_we), .rf_dst_sel(rf_dst_sel),
        .rf_wdata_sel(rf_wdata_sel), .muxt_alu_a(muxt_alu_a), .muxt_alu_b(muxt_alu_b),
        .alu_op(alu_op), .retire(retire), .retired_cnt(retired_cnt), .state_o(state_o)
    );

    mc_ctrl_fsm #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .mem(m4), .op(op), .funct(funct), .rs(rs),
        .alu_zero(alu_zero), .ir_we(ir_we_4), .pc_we(pc_we_4), .pc_src(pc_src_4),
        .alu_out_we(alu_out_we_4), .rf_we(rf_we_4), .rf_dst_sel(rf_dst_sel_4),
        .rf_wdata_sel(rf_wdata_sel_4), .muxt_alu_a(muxt_alu_a_4), .muxt_alu_b(muxt_alu_b_4),
        .alu_op(alu_op_4), .retire(retire_4), .retired_cnt(retired_cnt_4), .state_o(state_o_4)
    );

    typedef struct packed {
        logic [2:0] state;
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       alu_out_we;
        logic       rf_we;
        logic       rf_dst_sel;
        logic       rf_wdata_sel;
        logic [1:0] alu_a;
        logic [2:0] alu_b;
        logic [2:0] alu_op;
        logic       retire;
    } outs_t;

    outs_t obs;
    assign obs = {state_o, m32.imem_req, m32.dmem_req, m32.dmem_we, ir_we, pc_we, pc_src,
                  alu_out_we, rf_we, rf_dst_sel, rf_wdata_sel, muxt_alu_a, muxt_alu_b,
                  alu_op, retire};

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_cnt = 32'd0;

    // Instruction classes of the reference model
    localparam int K_NOP = 0, K_R = 1, K_ADDI = 2, K_ORI = 3, K_LW = 4,
                   K_SW = 5, K_BEQ = 6, K_J = 7, K_MFC0 = 8;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int cls_of(input logic [5:0] o, input logic [4:0] r);
        case (o)
            6'h00: return K_R;
            6'h08: return K_ADDI;
            6'h0D: return K_ORI;
            6'h23: return K_LW;
            6'h2B: return K_SW;
            6'h04: return K_BEQ;
            6'h02: return K_J;
            6'h10: return (r == 5'd0) ? K_MFC0 : K_NOP;
            default: return K_NOP;
        endcase
    endfunction

    // Everything quiet except ALU-B parked at "none"
    function automatic outs_t idle(input logic [2:0] st);
        outs_t o;
        o       = '0;
        o.alu_b = 3'd7;
        o.state = st;
        return o;
    endfunction

    // One clock: outputs checked mid-cycle, counters checked just after the edge.
    task automatic cyc(input string tag, input outs_t e);
        #2;
        check_eq($sformatf("%s_op%02h", tag, op), 32'(obs), 32'(e));
        if (e.retire) model_cnt = model_cnt + 32'd1;
        @(posedge clk);
        #1;
        check_eq($sformatf("cnt32_%s", tag), retired_cnt, model_cnt);
        check_eq($sformatf("cnt4_%s", tag), {28'd0, retired_cnt_4}, model_cnt & 32'hF);
    endtask

    task automatic stray_inputs();
        imem_ready = 1'($urandom);
        dmem_ready = 1'($urandom);
        alu_zero   = 1'($urandom);
    endtask

    // Release sequence: one RST cycle with rst_n high, then IF.
    task automatic release_reset();
        rst_n = 1'b1;
        stray_inputs();
        cyc("rst_rel", idle(3'd0));
    endtask

    // abort_mem > 0: assert reset asynchronously after that many MEM wait cycles.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r,
                             input int iw, input int dw, input logic z, input int abort_mem);
        outs_t e;
        int    k;
        op = o; funct = f; rs = r;
        k  = cls_of(o, r);

        for (int i = 0; i < iw; i++) begin
            stray_inputs();
            imem_ready = 1'b0;
            e = idle(3'd1); e.imem_req = 1'b1; e.alu_b = 3'd0;
            cyc("if_wait", e);
        end
        stray_inputs();
        imem_ready = 1'b1;
        e = idle(3'd1); e.imem_req = 1'b1; e.alu_b = 3'd0; e.ir_we = 1'b1; e.pc_we = 1'b1;
        cyc("if_go", e);

        stray_inputs();
        e = idle(3'd2); e.alu_b = 3'd3; e.alu_out_we = 1'b1; e.retire = (k == K_NOP);
        cyc("id", e);
        if (k == K_NOP) return;

        stray_inputs();
        e = idle(3'd3);
        case (k)
            K_R:          begin e.alu_a = 2'd1; e.alu_b = 3'd1; e.alu_op = 3'd2; e.alu_out_we = 1'b1; end
            K_ADDI:       begin e.alu_a = 2'd1; e.alu_b = 3'd2; e.alu_op = 3'd0; e.alu_out_we = 1'b1; end
            K_ORI:        begin e.alu_a = 2'd1; e.alu_b = 3'd2; e.alu_op = 3'd3; e.alu_out_we = 1'b1; end
            K_LW, K_SW:   begin e.alu_a = 2'd1; e.alu_b = 3'd2; e.alu_op = 3'd0; e.alu_out_we = 1'b1; end
            K_BEQ: begin
                alu_zero = z;
                e.alu_a = 2'd1; e.alu_b = 3'd1; e.alu_op = 3'd1;
                e.pc_we = z; e.pc_src = 2'd1; e.retire = 1'b1;
            end
            K_J:          begin e.pc_we = 1'b1; e.pc_src = 2'd2; e.retire = 1'b1; end
            K_MFC0:       begin e.alu_a = 2'd2; e.alu_b = 3'd5; e.alu_op = 3'd0; e.alu_out_we = 1'b1; end
            default: ;
        endcase
        cyc("ex", e);
        if (k == K_BEQ || k == K_J) return;

        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i < dw; i++) begin
                if (abort_mem > 0 && i == abort_mem) begin
                    // Reset mid-wait, well away from any clock edge.
                    #2;
                    rst_n = 1'b0;
                    #1;
                    check_eq("arst_state", {29'd0, state_o}, 32'd0);
                    check_eq("arst_dmem_req", {31'd0, m32.dmem_req}, 32'd0);
                    check_eq("arst_alu_b", {29'd0, muxt_alu_b}, 32'd7);
                    check_eq("arst_all", 32'(obs), 32'(idle(3'd0)));
                    check_eq("arst_cnt32", retired_cnt, 32'd0);
                    check_eq("arst_cnt4", {28'd0, retired_cnt_4}, 32'd0);
                    model_cnt = 32'd0;
                    @(posedge clk);
                    #1;
                    check_eq("arst_hold", 32'(obs), 32'(idle(3'd0)));
                    release_reset();
                    return;
                end
                stray_inputs();
                dmem_ready = 1'b0;
                e = idle(3'd4); e.dmem_req = 1'b1; e.dmem_we = (k == K_SW);
                cyc("mem_wait", e);
            end
            stray_inputs();
            dmem_ready = 1'b1;
            e = idle(3'd4); e.dmem_req = 1'b1; e.dmem_we = (k == K_SW); e.retire = (k == K_SW);
            cyc("mem_go", e);
            if (k == K_SW) return;
        end

        stray_inputs();
        e = idle(3'd5); e.rf_we = 1'b1; e.rf_dst_sel = (k == K_R);
        e.rf_wdata_sel = (k == K_LW); e.retire = 1'b1;
        cyc("wb", e);
    endtask

    task automatic run_random(input int n);
        logic [5:0] ops [9];
        logic [5:0] o;
        logic [4:0] r;
        ops = '{6'h00, 6'h08, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h10, 6'h00};
        for (int i = 0; i < n; i++) begin
            o = ops[$urandom_range(0, 8)];
            if (i % 9 == 8) o = 6'($urandom);
            r = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom);
            run_instr(o, 6'($urandom), r, $urandom_range(0, 2), $urandom_range(0, 3),
                      1'($urandom), 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; op = '0; funct = '0; rs = '0;
        alu_zero = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_outs", 32'(obs), 32'(idle(3'd0)));
        check_eq("rst_cnt", retired_cnt, 32'd0);
        release_reset();

        // Directed: R-type, LW with wait, BEQ taken/not, MFC0, unknown op, J, SW, ADDI, ORI
        run_instr(6'h00, 6'h20, 5'd3, 0, 0, 1'b0, 0);
        check_eq("r_retired", retired_cnt, 32'd1);
        run_instr(6'h23, 6'h00, 5'd1, 1, 3, 1'b0, 0);
        run_instr(6'h04, 6'h00, 5'd2, 0, 0, 1'b1, 0);
        run_instr(6'h04, 6'h00, 5'd2, 0, 0, 1'b0, 0);
        run_instr(6'h10, 6'h00, 5'd0, 0, 0, 1'b0, 0);
        run_instr(6'h3F, 6'h00, 5'd0, 2, 0, 1'b0, 0);
        run_instr(6'h10, 6'h00, 5'd4, 0, 0, 1'b0, 0);
        run_instr(6'h02, 6'h00, 5'd0, 0, 0, 1'b0, 0);
        run_instr(6'h2B, 6'h00, 5'd5, 0, 2, 1'b0, 0);
        run_instr(6'h08, 6'h00, 5'd6, 0, 0, 1'b0, 0);
        run_instr(6'h0D, 6'h00, 5'd7, 0, 0, 1'b0, 0);

        // Async reset while LW waits in MEM
        run_instr(6'h23, 6'h00, 5'd1, 0, 5, 1'b0, 2);

        // 17 retirements wrap the 4-bit counter to 1
        run_random(17);
        check_eq("wrap17_cnt4", {28'd0, retired_cnt_4}, 32'd1);
        check_eq("wrap17_cnt32", retired_cnt, 32'd17);

        run_random(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
